// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: operand forwarding, load-use stall, dmem wait
// freeze and redirect flush sequencing for the 5-stage RV32 pipeline.
module pipeline_hazard_ctrl #(
    parameter int REG_AW      = 5,
    parameter int LOAD_LAT    = 1,
    parameter int FLUSH_EXTRA = 0,
    parameter int FWD_EN      = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] de_adr1,
    input  logic [REG_AW-1:0] de_adr2,
    input  logic              de_rs1_used,
    input  logic              de_rs2_used,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              ex_regWrite,
    input  logic              mem_regWrite,
    input  logic              wb_regWrite,
    input  logic              ex_is_load,
    input  logic              mem_is_jal,
    input  logic              mem_access,
    input  logic              dmem_ready,
    input  logic              ex_redirect,
    output logic [1:0]        fsel1,
    output logic [1:0]        fsel2,
    output logic              stall_if,
    output logic              stall_de,
    output logic              bubble_ex,
    output logic              flush_de,
    output logic              freeze,
    output logic [1:0]        hz_state
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        MWAIT  = 2'd2,
        FLUSH  = 2'd3
    } state_t;

    localparam logic [2:0] LS_INIT = 3'(LOAD_LAT - 1);
    localparam logic [2:0] FL_INIT = 3'(FLUSH_EXTRA);
    localparam logic       USE_FWD = (FWD_EN != 0);

    state_t     state;
    state_t     saved;
    logic [2:0] cnt;
    logic       mwait;
    logic       load_use;
    logic       raw;
    logic [1:0] fs1;
    logic [1:0] fs2;

    function automatic logic hit(
        input logic [REG_AW-1:0] rd,
        input logic              we,
        input logic              used,
        input logic [REG_AW-1:0] adr
    );
        return we && used && (rd != '0) && (rd == adr);
    endfunction

    // Hazard conditions seen by the DE-stage instruction this cycle
    always_comb begin
        mwait    = mem_access & ~dmem_ready;
        load_use = ex_is_load &
                   (hit(ex_rd, 1'b1, de_rs1_used, de_adr1) |
                    hit(ex_rd, 1'b1, de_rs2_used, de_adr2));
        raw      = ~USE_FWD &
                   (hit(ex_rd,  ex_regWrite,  de_rs1_used, de_adr1) |
                    hit(ex_rd,  ex_regWrite,  de_rs2_used, de_adr2) |
                    hit(mem_rd, mem_regWrite, de_rs1_used, de_adr1) |
                    hit(mem_rd, mem_regWrite, de_rs2_used, de_adr2) |
                    hit(wb_rd,  wb_regWrite,  de_rs1_used, de_adr1) |
                    hit(wb_rd,  wb_regWrite,  de_rs2_used, de_adr2));
    end

    // Operand mux selects, EX result wins over MEM result
    always_comb begin
        fs1 = 2'b00;
        fs2 = 2'b00;
        if (USE_FWD) begin
            if (hit(ex_rd, ex_regWrite, de_rs1_used, de_adr1))
                fs1 = 2'b01;
            else if (hit(mem_rd, mem_regWrite, de_rs1_used, de_adr1))
                fs1 = mem_is_jal ? 2'b11 : 2'b10;
            if (hit(ex_rd, ex_regWrite, de_rs2_used, de_adr2))
                fs2 = 2'b01;
            else if (hit(mem_rd, mem_regWrite, de_rs2_used, de_adr2))
                fs2 = mem_is_jal ? 2'b11 : 2'b10;
        end
    end

    // Pipeline control for this cycle; all quiet while reset is held
    always_comb begin
        fsel1     = 2'b00;
        fsel2     = 2'b00;
        stall_if  = 1'b0;
        stall_de  = 1'b0;
        bubble_ex = 1'b0;
        flush_de  = 1'b0;
        freeze    = 1'b0;
        if (rst_n) begin
            fsel1 = fs1;
            fsel2 = fs2;
            if (mwait) begin
                freeze   = 1'b1;
                stall_if = 1'b1;
                stall_de = 1'b1;
            end else begin
                unique case (state)
                    RUN: begin
                        if (ex_redirect) begin
                            flush_de  = 1'b1;
                            bubble_ex = 1'b1;
                        end else if (load_use || raw) begin
                            stall_if  = 1'b1;
                            stall_de  = 1'b1;
                            bubble_ex = 1'b1;
                        end
                    end
                    LSTALL: begin
                        stall_if  = 1'b1;
                        stall_de  = 1'b1;
                        bubble_ex = 1'b1;
                    end
                    FLUSH: begin
                        flush_de  = 1'b1;
                        bubble_ex = ex_redirect;
                    end
                    MWAIT: begin
                    end
                endcase
            end
        end
    end

    // Sequencer: memory wait parks the current state and counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            saved <= RUN;
            cnt   <= 3'd0;
        end else if (mwait) begin
            if (state != MWAIT)
                saved <= state;
            state <= MWAIT;
        end else begin
            unique case (state)
                RUN: begin
                    if (ex_redirect) begin
                        if (FLUSH_EXTRA > 0) begin
                            state <= FLUSH;
                            cnt   <= FL_INIT;
                        end
                    end else if (load_use) begin
                        if (LOAD_LAT > 1) begin
                            state <= LSTALL;
                            cnt   <= LS_INIT;
                        end
                    end
                end
                LSTALL: begin
                    cnt <= cnt - 3'd1;
                    if (cnt <= 3'd1)
                        state <= RUN;
                end
                FLUSH: begin
                    if (ex_redirect) begin
                        cnt <= FL_INIT;
                    end else begin
                        cnt <= cnt - 3'd1;
                        if (cnt <= 3'd1)
                            state <= RUN;
                    end
                end
                MWAIT: state <= saved;
            endcase
        end
    end

    assign hz_state = state;

endmodule
